// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect unit: widths, reset PC, jump polarity and FSM encodings.
package pc_redirect_unit_pkg;

   localparam int unsigned PC_W     = 16;
   localparam logic [15:0] RESET_PC = 16'h0000;

   localparam logic PC_JUMP_ENABLE  = 1'b1;
   localparam logic PC_JUMP_DISABLE = 1'b0;

   localparam logic PCR_ST_RUN     = 1'b0;
   localparam logic PCR_ST_PENDING = 1'b1;

   typedef enum logic {
      StRun     = PCR_ST_RUN,
      StPending = PCR_ST_PENDING
   } pcr_state_e;

endpackage

// File: rtl/pc_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module pc_sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {Width{1'b1}})) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Owns the fetch PC: sequential stepping, jump redirects with flush, and a one-entry redirect
// buffer used while instruction memory is busy so no taken jump is lost.
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter int unsigned PcW     = PC_W,
   parameter logic [PcW-1:0] ResetPc = PcW'(RESET_PC),
   parameter int unsigned CntW    = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            jump_en_i,
   input  logic [PcW-1:0]  jump_target_i,
   input  logic            stall_i,
   input  logic            imem_ready_i,
   output logic [PcW-1:0]  pc_o,
   output logic [PcW-1:0]  pc_plus1_o,
   output logic            imem_req_o,
   output logic            flush_if_id_o,
   output logic            flush_id_ex_o,
   output logic            redirect_pending_o,
   output logic [CntW-1:0] redirect_cnt_o
);

   pcr_state_e     state_q, state_d;
   logic [PcW-1:0] pc_q, pc_d;
   logic [PcW-1:0] tgt_q, tgt_d;
   logic           accept;
   logic           req;
   logic           flush;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      accept  = 1'b0;
      req     = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         StRun: begin
            req = 1'b1;
            if (jump_en_i == PC_JUMP_ENABLE) begin
               accept = 1'b1;
               flush  = 1'b1;
               // A jump wins over a load-use stall; only a busy memory defers it.
               if (imem_ready_i) begin
                  pc_d = jump_target_i;
               end else begin
                  tgt_d   = jump_target_i;
                  state_d = StPending;
               end
            end else if (imem_ready_i && !stall_i) begin
               pc_d = pc_q + PcW'(1);
            end
         end
         StPending: begin
            // Jumps seen here are from wrong-path instructions and are dropped.
            flush = 1'b1;
            if (imem_ready_i) begin
               pc_d    = tgt_q;
               state_d = StRun;
            end
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StRun;
         pc_q    <= ResetPc;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

   pc_sat_counter #(
      .Width(CntW)
   ) u_redirect_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (accept),
      .cnt_o (redirect_cnt_o)
   );

   // Control outputs are held low while reset is asserted.
   assign imem_req_o         = req & rst_ni;
   assign flush_if_id_o      = flush & rst_ni;
   assign flush_id_ex_o      = flush & rst_ni;
   assign redirect_pending_o = (state_q == StPending);
   assign pc_o               = pc_q;
   assign pc_plus1_o         = pc_q + PcW'(1);

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Program-counter owner and redirect consumer: sits at the fetch end of the branch path and acts on the jump_en / target pair produced by the EX-stage jump-enable logic. It holds the PC and steps it sequentially. It turns an asserted jump_en into a PC redirect plus pipeline flush. If instruction fetch is blocked by a memory conflict, it buffers the redirect so that no taken jump is lost.

Parameters:
PC_W, 16, PC / target width
RESET_PC, 16'h0000, PC value loaded on reset
CNT_W, 16, width of saturating taken-redirect counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
jump_en  in  1  redirect request from EX-stage jump-enable logic (1 = take)
jump_target  in  PC_W  redirect destination, valid when jump_en=1
stall  in  1  hazard-unit PC hold (load-use)
imem_ready  in  1  instruction memory free this cycle (0 = data access owns RAM)
pc  out  PC_W  current fetch address
pc_plus1  out  PC_W  pc+1, mod 2^PC_W
imem_req  out  1  fetch request for pc
flush_if_id  out  1  load bubble into IF/ID at next edge
flush_id_ex  out  1  load bubble into ID/EX at next edge
redirect_pending  out  1  high while state=PENDING
redirect_cnt  out  CNT_W  count of accepted redirects, saturating

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=RUN, pending_target=0, redirect_cnt=0.
  - All 1-bit outputs low except imem_req, which goes high after rst deasserts.
- States: RUN, PENDING.
- RUN:
  - imem_req=1.
  - advance = imem_ready & ~stall.
  - jump_en=1 and imem_ready=1: pc<=jump_target at the next edge; state stays RUN. Jump overrides stall.
  - jump_en=1 and imem_ready=0: pending_target<=jump_target; state<=PENDING; pc unchanged.
  - jump_en=0 and advance=1: pc<=pc+1, wrapping 16'hFFFF to 16'h0000.
  - jump_en=0 and advance=0: pc holds.
  - flush_if_id = flush_id_ex = jump_en (combinational, same cycle as jump_en).
- PENDING:
  - imem_req=0; no wrong-path fetch.
  - flush_if_id=flush_id_ex=1 every cycle.
  - imem_ready=1: pc<=pending_target; state<=RUN. stall is ignored.
  - imem_ready=0: hold.
  - jump_en in PENDING comes from a wrong-path instruction. It is ignored, and pending_target keeps its value.
- redirect_cnt:
  - +1 on each accepted jump_en, i.e. jump_en=1 while in RUN.
  - Saturates at all-ones.
- Latency: jump_en in cycle N → pc=target in cycle N+1 if imem_ready, else in the first cycle after imem_ready returns high.
- pc_plus1 is combinational from pc. imem_req and the flush outputs are combinational from state/inputs.
- Reset asserted mid-PENDING: the pending redirect is discarded and pc=RESET_PC.
- jump_target equal to the current pc is legal; it still flushes.
- X on jump_target when jump_en=0 must not propagate to pc.

Decomposition:
- Shared define package holds:
  - PC_W
  - RESET_PC
  - PC_JUMP_ENABLE / PC_JUMP_DISABLE encodings, reused for the jump_en polarity
  - state encodings PCR_ST_RUN=1'b0, PCR_ST_PENDING=1'b1
- One natural sub-module: pc_sat_counter (parameterised saturating counter for redirect_cnt).
- The PC register and FSM stay flat in this block.

Test Plan:
- Reset then release, imem_ready=1, stall=0 for 4 cycles → pc = 0000,0001,0002,0003; flushes low; redirect_cnt=0.
- At pc=0005 pulse jump_en=1, jump_target=0040, imem_ready=1 → flushes high that cycle only; next cycle pc=0040, then 0041; redirect_cnt=1.
- jump_en=1, target=0080, imem_ready=0 for 3 cycles → redirect_pending=1, imem_req=0, flushes high, pc frozen. A wrong-path jump_en to 0099 during the hold is ignored. imem_ready=1 → pc=0080 next cycle, state RUN.
- stall=1 with jump_en=1, target=0010, imem_ready=1 → pc=0010 next cycle (jump overrides stall). stall=1 alone → pc holds.
- pc=FFFF, advance → pc=0000, pc_plus1=0001. Force redirect_cnt to FFFF, then accept a jump → stays FFFF.
- Assert rst low while PENDING (target 0200) → pc=RESET_PC immediately, redirect_pending=0. After release, the fetch sequence restarts from 0000 with no jump to 0200.
